// File: rtl/conv_pkg.sv
// Shared types, Sobel weights and saturation helper for the 3x3 convolution stage.
package conv_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_GX   = 2'd1,
    MODE_GY   = 2'd2,
    MODE_MAG  = 2'd3
  } mode_e;

  localparam int unsigned SOBEL_CORNER = 1;
  localparam int unsigned SOBEL_EDGE   = 2;

  // Saturate an unsigned value to the largest code representable in 'width' bits.
  function automatic logic [31:0] clip_sat(input logic [31:0] value, input int unsigned width);
    logic [31:0] max_val;
    max_val = (32'd1 << width) - 32'd1;
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/conv3x3_stream_filter_if.sv
// Pixel stream bus between the source and the 3x3 convolution stage.
interface conv3x3_stream_filter_if #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned COL_W  = 10,
  parameter int unsigned ROW_W  = 9
);
  logic              iSOF;
  logic              iDVAL;
  logic [DATA_W-1:0] iDATA;
  logic [1:0]        iMODE;
  logic [DATA_W-1:0] iTHRESH;
  logic              oDVAL;
  logic [DATA_W-1:0] oDATA;
  logic [COL_W-1:0]  oCOL;
  logic [ROW_W-1:0]  oROW;

  modport master (
    output iSOF, iDVAL, iDATA, iMODE, iTHRESH,
    input  oDVAL, oDATA, oCOL, oROW
  );

  modport slave (
    input  iSOF, iDVAL, iDATA, iMODE, iTHRESH,
    output oDVAL, oDATA, oCOL, oROW
  );
endinterface

// File: rtl/line_buffer.sv
// One image line of pixels: combinational read, synchronous write, shared address.
module line_buffer #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned DEPTH  = 640,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [AW-1:0]     addr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Old contents are visible in the same cycle they are overwritten
  assign rdata_c = mem[addr];

  // Write the accepted pixel's column slot
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/conv3x3_stream_filter.sv
// Streaming 3x3 Sobel stage: pass / |Gx| / |Gy| / |Gx|+|Gy|, mode latched at start of frame.
// Optional build macro CONV_THRESHOLD_EN binarises the output against iTHRESH.
module conv3x3_stream_filter
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned IMG_W  = 640,
  parameter int unsigned IMG_H  = 480,
  parameter int unsigned SHIFT  = 2
) (
  input logic iCLK,
  input logic iRST,
  conv3x3_stream_filter_if.slave bus
);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned SW    = DATA_W + 3;

  logic [COL_W-1:0]  col_q, cur_col_c, s1_col, s2_col;
  logic [ROW_W-1:0]  row_q, cur_row_c, s1_row, s2_row;
  mode_e             mode_q, cur_mode_c, s1_mode, s2_mode;
  logic [DATA_W-1:0] lb0_rd, lb1_rd, s1_pass, s2_pass, clip_c, res_c;
  logic [DATA_W-1:0] win [3][3];
  logic              s1_valid, s2_valid, s1_border, s2_border;
  logic [SW-1:0]     r_sum_c, l_sum_c, b_sum_c, t_sum_c, ax_c, ay_c, s2_ax, s2_ay, sel_c;
  logic signed [SW-1:0] gx_c, gy_c;
`ifdef CONV_THRESHOLD_EN
  logic [DATA_W-1:0] thresh_q, cur_thresh_c, s1_thresh, s2_thresh;
`endif

  // Position and mode of the pixel on the bus this cycle; iSOF forces (0,0)
  always_comb begin
    cur_col_c  = bus.iSOF ? '0 : col_q;
    cur_row_c  = bus.iSOF ? '0 : row_q;
    cur_mode_c = bus.iSOF ? mode_e'(bus.iMODE) : mode_q;
`ifdef CONV_THRESHOLD_EN
    cur_thresh_c = bus.iSOF ? bus.iTHRESH : thresh_q;
`endif
  end

  // Column/row tracking with start-of-frame resync, per-frame mode latch
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      col_q  <= '0;
      row_q  <= '0;
      mode_q <= MODE_PASS;
`ifdef CONV_THRESHOLD_EN
      thresh_q <= '0;
`endif
    end else begin
      if (bus.iDVAL) begin
        if (cur_col_c == COL_W'(IMG_W - 1)) begin
          col_q <= '0;
          row_q <= (cur_row_c == ROW_W'(IMG_H - 1)) ? '0 : cur_row_c + ROW_W'(1);
        end else begin
          col_q <= cur_col_c + COL_W'(1);
          row_q <= cur_row_c;
        end
      end else if (bus.iSOF) begin
        col_q <= '0;
        row_q <= '0;
      end
      mode_q <= cur_mode_c;
`ifdef CONV_THRESHOLD_EN
      thresh_q <= cur_thresh_c;
`endif
    end
  end

  // lb1 holds row r-1, lb0 holds row r-2; both shift down on each accepted pixel
  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk(iCLK), .addr(cur_col_c), .we(bus.iDVAL), .wdata(lb1_rd), .rdata_c(lb0_rd)
  );
  line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk(iCLK), .addr(cur_col_c), .we(bus.iDVAL), .wdata(bus.iDATA), .rdata_c(lb1_rd)
  );

  // Stage 0: shift the window on accepted pixels and capture pixel metadata
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
      s1_valid  <= 1'b0;
      s1_col    <= '0;
      s1_row    <= '0;
      s1_mode   <= MODE_PASS;
      s1_pass   <= '0;
      s1_border <= 1'b0;
`ifdef CONV_THRESHOLD_EN
      s1_thresh <= '0;
`endif
    end else begin
      s1_valid <= bus.iDVAL;
      if (bus.iDVAL) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb0_rd;
        win[1][2] <= lb1_rd;
        win[2][2] <= bus.iDATA;
        s1_col    <= cur_col_c;
        s1_row    <= cur_row_c;
        s1_mode   <= cur_mode_c;
        s1_pass   <= bus.iDATA;
        s1_border <= (cur_col_c < COL_W'(2)) || (cur_row_c < ROW_W'(2));
`ifdef CONV_THRESHOLD_EN
        s1_thresh <= cur_thresh_c;
`endif
      end
    end
  end

  // Sobel gradients on the current window (row 0 oldest, column 2 newest)
  always_comb begin
    r_sum_c = SW'(SOBEL_CORNER) * SW'(win[0][2]) + SW'(SOBEL_EDGE) * SW'(win[1][2])
            + SW'(SOBEL_CORNER) * SW'(win[2][2]);
    l_sum_c = SW'(SOBEL_CORNER) * SW'(win[0][0]) + SW'(SOBEL_EDGE) * SW'(win[1][0])
            + SW'(SOBEL_CORNER) * SW'(win[2][0]);
    b_sum_c = SW'(SOBEL_CORNER) * SW'(win[2][0]) + SW'(SOBEL_EDGE) * SW'(win[2][1])
            + SW'(SOBEL_CORNER) * SW'(win[2][2]);
    t_sum_c = SW'(SOBEL_CORNER) * SW'(win[0][0]) + SW'(SOBEL_EDGE) * SW'(win[0][1])
            + SW'(SOBEL_CORNER) * SW'(win[0][2]);
    gx_c = $signed(r_sum_c - l_sum_c);
    gy_c = $signed(b_sum_c - t_sum_c);
    ax_c = gx_c[SW-1] ? SW'(-gx_c) : SW'(gx_c);
    ay_c = gy_c[SW-1] ? SW'(-gy_c) : SW'(gy_c);
  end

  // Stage 1: register gradient magnitudes alongside the pixel metadata
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s2_valid  <= 1'b0;
      s2_col    <= '0;
      s2_row    <= '0;
      s2_mode   <= MODE_PASS;
      s2_pass   <= '0;
      s2_border <= 1'b0;
      s2_ax     <= '0;
      s2_ay     <= '0;
`ifdef CONV_THRESHOLD_EN
      s2_thresh <= '0;
`endif
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_col    <= s1_col;
        s2_row    <= s1_row;
        s2_mode   <= s1_mode;
        s2_pass   <= s1_pass;
        s2_border <= s1_border;
        s2_ax     <= ax_c;
        s2_ay     <= ay_c;
`ifdef CONV_THRESHOLD_EN
        s2_thresh <= s1_thresh;
`endif
      end
    end
  end

  // Mode select, scale, saturate, border blanking (filter modes only)
  always_comb begin
    sel_c = '0;
    case (s2_mode)
      MODE_GX:  sel_c = s2_ax;
      MODE_GY:  sel_c = s2_ay;
      MODE_MAG: sel_c = s2_ax + s2_ay;
      default:  sel_c = '0;
    endcase
    clip_c = DATA_W'(clip_sat(32'(sel_c >> SHIFT), DATA_W));
    if (s2_mode == MODE_PASS) res_c = s2_pass;
    else if (s2_border)       res_c = '0;
    else                      res_c = clip_c;
`ifdef CONV_THRESHOLD_EN
    res_c = (res_c >= s2_thresh) ? '1 : '0;
`endif
  end

  // Stage 2: output register; data/position hold between valid pixels
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      bus.oDVAL <= 1'b0;
      bus.oDATA <= '0;
      bus.oCOL  <= '0;
      bus.oROW  <= '0;
    end else begin
      bus.oDVAL <= s2_valid;
      if (s2_valid) begin
        bus.oDATA <= res_c;
        bus.oCOL  <= s2_col;
        bus.oROW  <= s2_row;
      end
    end
  end
endmodule
